pwm_multi: RTL

PWM_MULTI -- requirements
Module: pwm_multi

---
 rtl/pwm_multi.sv | 64 ++++++
 1 files changed

// File: rtl/pwm_multi.sv
// pwm_multi: multi-channel PWM with double-buffered duty registers; define PWM_MULTI_PHASE_EN to stagger channel phases.
module pwm_multi #(
  parameter int NCH = 4,
  parameter int CW = 17,
  parameter int PERIOD = 50000
) (
  input  logic                                 clk,
  input  logic                                 clr,
  input  logic                                 en,
  input  logic                                 wr_en,
  input  logic [(NCH > 1 ? $clog2(NCH) : 1)-1:0] wr_ch,
  input  logic [CW-1:0]                        wr_duty,
  output logic [NCH-1:0]                       pwm_out,
  output logic                                 cycle_start
);
  localparam int CHW = NCH > 1 ? $clog2(NCH) : 1;
  localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);
  if (NCH < 1 || NCH > 16) begin : g_bad_nch
    $error("pwm_multi: NCH must be in 1..16");
  end
  if (PERIOD < 2 || longint'(PERIOD) > (longint'(1) << CW) - 1) begin : g_bad_period
    $error("pwm_multi: PERIOD must be in 2..2**CW-1");
  end
  logic [CW-1:0] cnt;
  logic [CW-1:0] shadow [NCH];
  logic [CW-1:0] active [NCH];
  logic [CW-1:0] shadow_nxt [NCH];
  logic [CW-1:0] ph [NCH];
  logic [NCH-1:0] load;
  logic [NCH-1:0] hi;
  for (genvar g = 0; g < NCH; g++) begin : g_ch
    assign shadow_nxt[g] = (wr_en && wr_ch == CHW'(g)) ? wr_duty : shadow[g];
`ifdef PWM_MULTI_PHASE_EN
    // phase count = (cnt - offset) mod PERIOD, computed one bit wider to avoid overflow
    localparam int OFF = g * (PERIOD / NCH);
    logic [CW:0] sum;
    assign sum = {1'b0, cnt} + (CW+1)'(PERIOD - OFF);
    assign ph[g] = sum >= (CW+1)'(PERIOD) ? CW'(sum - (CW+1)'(PERIOD)) : CW'(sum);
`else
    assign ph[g] = cnt;
`endif
    assign load[g] = ph[g] == LAST;
    assign hi[g] = ph[g] < active[g];
  end
  always_ff @(posedge clk) begin
    if (clr) begin
      cnt <= '0;
      pwm_out <= '0;
      cycle_start <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        shadow[i] <= shadow_nxt[i];
        if (!en || load[i]) active[i] <= shadow_nxt[i];
      end
      cnt <= (!en || cnt == LAST) ? '0 : cnt + 1'b1;
      pwm_out <= en ? hi : '0;
      cycle_start <= en && cnt == '0;
    end
  end
endmodule
